// File: rtl/uart_driver_pkg.sv
// uart_driver_pkg: shared sizing helper for the UART engine.
package uart_driver_pkg;

    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: reloadable down-counter; done is high while the count sits at zero.
module uart_bit_timer #(
    parameter int W = 7
) (
    input  logic         sys_clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge sys_clk) begin
        if (rst) cnt <= '0;
        else if (load) cnt <= value;
        else if (cnt != '0) cnt <= cnt - 1'b1;
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/uart_driver.sv
// uart_driver: full-duplex UART, independent RX deserializer and TX serializer.
module uart_driver
    import uart_driver_pkg::*;
#(
    parameter int BIT_DURATION  = 104,
    parameter int NUM_DATA_BITS = 8
) (
    input  logic                     sys_clk,
    input  logic                     rst,
    input  logic                     rx_in,
    input  logic                     cmd_tx_start,
    input  logic [NUM_DATA_BITS-1:0] tx_data,
    output logic                     tx_out,
    output logic                     rx_new_data,
    output logic                     rx_ready,
    output logic                     tx_ready,
    output logic [NUM_DATA_BITS-1:0] rx_data
);

    localparam int N  = NUM_DATA_BITS;
    localparam int BW = cnt_width(BIT_DURATION);
    localparam int IW = cnt_width(NUM_DATA_BITS + 1);
    localparam logic [BW-1:0] FULL  = BW'(BIT_DURATION - 1);
    localparam logic [BW-1:0] HALF  = BW'(BIT_DURATION / 2 - 1);
    localparam logic [IW-1:0] LAST  = IW'(N - 1);
    localparam logic [IW-1:0] NBITS = IW'(N);
    localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;

    logic rx_meta, rx_sync, rx_prev, rx_fall;
    logic [1:0] rx_state, tx_state;
    logic [IW-1:0] rx_idx, tx_idx;
    logic [N-1:0] rx_shift, tx_shift;
    logic rx_done, rx_load, tx_done, tx_load;
    logic [BW-1:0] rx_value;

    always_ff @(posedge sys_clk) begin
        if (rst) {rx_meta, rx_sync, rx_prev} <= '1;
        else {rx_meta, rx_sync, rx_prev} <= {rx_in, rx_meta, rx_sync};
    end

    assign rx_fall  = rx_prev & ~rx_sync;
    assign rx_ready = (rx_state == IDLE);
    assign tx_ready = (tx_state == IDLE);
    assign rx_load  = rx_ready ? rx_fall : rx_done;
    assign rx_value = rx_ready ? HALF : FULL;
    assign tx_load  = tx_ready ? cmd_tx_start : tx_done;

    uart_bit_timer #(.W(BW)) rx_timer (.sys_clk, .rst, .load(rx_load), .value(rx_value), .done(rx_done));
    uart_bit_timer #(.W(BW)) tx_timer (.sys_clk, .rst, .load(tx_load), .value(FULL), .done(tx_done));

    // Falling-edge hunting means a framing error with the line stuck low waits for it to go high first.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            rx_state    <= IDLE;
            rx_idx      <= '0;
            rx_shift    <= '0;
            rx_data     <= '0;
            rx_new_data <= 1'b0;
        end else begin
            rx_new_data <= 1'b0;
            case (rx_state)
                IDLE:  if (rx_fall) rx_state <= START;
                START: if (rx_done) begin
                    rx_state <= rx_sync ? IDLE : DATA;
                    rx_idx   <= '0;
                end
                DATA:  if (rx_done) begin
                    rx_shift <= (rx_shift >> 1) | (N'(rx_sync) << (N - 1));
                    rx_idx   <= rx_idx + 1'b1;
                    if (rx_idx == LAST) rx_state <= STOP;
                end
                default: if (rx_done) begin
                    rx_state <= IDLE;
                    if (rx_sync) begin
                        rx_data     <= rx_shift;
                        rx_new_data <= 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            tx_state <= IDLE;
            tx_out   <= 1'b1;
            tx_idx   <= '0;
            tx_shift <= '0;
        end else begin
            case (tx_state)
                IDLE:  if (cmd_tx_start) begin
                    tx_state <= START;
                    tx_out   <= 1'b0;
                    tx_shift <= tx_data;
                end
                START: if (tx_done) begin
                    tx_state <= DATA;
                    tx_out   <= tx_shift[0];
                    tx_shift <= tx_shift >> 1;
                    tx_idx   <= IW'(1);
                end
                DATA:  if (tx_done) begin
                    if (tx_idx == NBITS) begin
                        tx_state <= STOP;
                        tx_out   <= 1'b1;
                    end else begin
                        tx_out   <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                        tx_idx   <= tx_idx + 1'b1;
                    end
                end
                default: if (tx_done) tx_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_driver.sv
// tb_uart_driver: directed self-checking bench for uart_driver (12 data bits, 104 cycles per bit).
module tb_uart_driver;

    localparam int B = 104;
    localparam int N = 12;

    logic clk = 1'b0, rst = 1'b1, rx_in = 1'b1, cmd_tx_start = 1'b0;
    logic [N-1:0] tx_data = '0;
    logic tx_out, rx_new_data, rx_ready, tx_ready;
    logic [N-1:0] rx_data;

    int checks = 0, failures = 0, cyc = 0, pulses = 0;
    logic [N-1:0] got[$];

    always #5 clk = ~clk;

    uart_driver #(.BIT_DURATION(B), .NUM_DATA_BITS(N)) dut (
        .sys_clk(clk), .rst(rst), .rx_in(rx_in), .cmd_tx_start(cmd_tx_start), .tx_data(tx_data),
        .tx_out(tx_out), .rx_new_data(rx_new_data), .rx_ready(rx_ready), .tx_ready(tx_ready), .rx_data(rx_data)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rx_new_data) begin
            pulses <= pulses + 1;
            got.push_back(rx_data);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rx_frame(input logic [N-1:0] w, input logic stop);
        logic [N+1:0] f;
        f = {stop, w, 1'b0};
        @(negedge clk);
        for (int b = 0; b < N + 2; b++) begin
            rx_in = f[b];
            repeat (B) @(negedge clk);
            if (b == 2) chk("rx_busy", 32'(rx_ready), 32'd0);
        end
    endtask

    task automatic tx_frame(input logic [N-1:0] w, input logic poke);
        int t0;
        logic e;
        @(negedge clk);
        tx_data = w;
        cmd_tx_start = 1'b1;
        @(posedge clk);
        #1;
        cmd_tx_start = 1'b0;
        tx_data = ~w;
        t0 = cyc;
        chk("tx_accept", 32'(tx_ready), 32'd0);
        for (int b = 0; b < N + 2; b++) begin
            wait_cyc(t0 + b * B + B / 2);
            e = (b == 0) ? 1'b0 : (b <= N) ? w[b-1] : 1'b1;
            chk("tx_bit", 32'(tx_out), 32'(e));
            if (poke && b == 3) begin
                @(negedge clk);
                tx_data = 12'h0B5;
                cmd_tx_start = 1'b1;
                @(posedge clk);
                #1;
                cmd_tx_start = 1'b0;
            end
        end
        wait_cyc(t0 + (N + 2) * B - 1);
        chk("tx_busy_end", 32'(tx_ready), 32'd0);
        wait_cyc(t0 + (N + 2) * B);
        chk("tx_ready_back", 32'(tx_ready), 32'd1);
        chk("tx_line_idle", 32'(tx_out), 32'd1);
    endtask

    initial begin
        int p;
        repeat (3) @(negedge clk);
        chk("rst_tx_out", 32'(tx_out), 32'd1);
        chk("rst_tx_ready", 32'(tx_ready), 32'd1);
        chk("rst_rx_ready", 32'(rx_ready), 32'd1);
        chk("rst_rx_new", 32'(rx_new_data), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        rst = 1'b0;
        // single RX frame
        rx_frame(12'h4CA, 1'b1);
        repeat (20) @(negedge clk);
        chk("rx1_pulses", 32'(pulses), 32'd1);
        chk("rx1_word", 32'(got[0]), 32'h4CA);
        chk("rx1_rx_ready", 32'(rx_ready), 32'd1);
        // short-idle back-to-back frames
        repeat (177) @(negedge clk);
        rx_frame(12'hF10, 1'b1);
        repeat (62) @(negedge clk);
        rx_frame(12'h51D, 1'b1);
        repeat (20) @(negedge clk);
        chk("rx2_pulses", 32'(pulses), 32'd3);
        chk("rx2_word_a", 32'(got[1]), 32'hF10);
        chk("rx2_word_b", 32'(got[2]), 32'h51D);
        chk("rx2_data", 32'(rx_data), 32'h51D);
        // TX frames, the first with an ignored mid-frame request
        tx_frame(12'h4F6, 1'b1);
        tx_frame(12'h0B5, 1'b0);
        tx_frame(12'hE91, 1'b0);
        // framing error then a short glitch
        rx_frame(12'h2A5, 1'b0);
        rx_in = 1'b1;
        repeat (2 * B) @(negedge clk);
        chk("frm_pulses", 32'(pulses), 32'd3);
        chk("frm_data", 32'(rx_data), 32'h51D);
        rx_in = 1'b0;
        repeat (20) @(negedge clk);
        rx_in = 1'b1;
        repeat (2 * B) @(negedge clk);
        chk("glitch_pulses", 32'(pulses), 32'd3);
        chk("glitch_ready", 32'(rx_ready), 32'd1);
        rx_frame(12'h3C3, 1'b1);
        repeat (20) @(negedge clk);
        chk("rx3_pulses", 32'(pulses), 32'd4);
        chk("rx3_data", 32'(rx_data), 32'h3C3);
        // reset in the middle of both paths
        @(negedge clk);
        tx_data = '0;
        cmd_tx_start = 1'b1;
        rx_in = 1'b0;
        @(negedge clk);
        cmd_tx_start = 1'b0;
        repeat (3 * B) @(negedge clk);
        chk("mid_tx_out", 32'(tx_out), 32'd0);
        chk("mid_tx_ready", 32'(tx_ready), 32'd0);
        chk("mid_rx_ready", 32'(rx_ready), 32'd0);
        p = pulses;
        rst = 1'b1;
        rx_in = 1'b1;
        @(posedge clk);
        #1;
        chk("rst2_tx_out", 32'(tx_out), 32'd1);
        chk("rst2_tx_ready", 32'(tx_ready), 32'd1);
        chk("rst2_rx_ready", 32'(rx_ready), 32'd1);
        chk("rst2_rx_data", 32'(rx_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2000) @(negedge clk);
        chk("rst2_no_pulse", 32'(pulses), 32'(p));
        chk("rst2_line", 32'(tx_out), 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
